reg_write_scoreboard: RTL and testbench
=======================================

// Module: reg_write_scoreboard
// PURPOSE
//  Consumer of the destination decode output (rd, we_reg) at issue. Records every in-flight register write
//  in an in-order queue, keeps a per-register pending count, and stalls issue while a source register has
//  an outstanding write (RAW). Writeback pops the queue in order.
// PARAMETERS
//  DEPTH   4   max in-flight register writes (power of 2, >=2)
//  CNT_W   3   per-register count width; must satisfy 2**CNT_W > DEPTH
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  id_valid    in   1      instruction present at issue
//  id_rs       in   3      source register 1
//  id_rs_en    in   1      instruction reads id_rs
//  id_rt       in   3      source register 2
//  id_rt_en    in   1      instruction reads id_rt
//  id_rd       in   3      destination register, from destination decode
//  id_we_reg   in   1      instruction writes id_rd, from destination decode
//  retire      in   1      oldest in-flight write completes this cycle
//  flush       in   1      discard all in-flight writes
//  stall       out  1      combinational; issue blocked this cycle
//  retire_rd   out  3      destination at queue head (valid when !empty)
//  pending     out  8      bit r = count[r] != 0
//  full        out  1      occupancy == DEPTH
//  empty       out  1      occupancy == 0
//  occupancy   out  clog2(DEPTH)+1  entries in queue
//  err_underflow out 1     sticky: retire seen while empty
// BEHAVIOUR
//  Reset: queue empty, all counts 0, pointers 0, err_underflow 0; stall 0, pending 0, full 0, empty 1,
//   occupancy 0, retire_rd 0. Reset asserted mid-operation clears all state immediately.
//  raw  = (id_rs_en && count[id_rs]!=0) || (id_rt_en && count[id_rt]!=0), subject to bypass below.
//  stall = id_valid && (raw || (id_we_reg && full)). Full is evaluated on current state, not net of retire.
//  accept = id_valid && !stall && !flush.
//  On accept with id_we_reg: push id_rd at tail, count[id_rd]++ at next edge.
//  Writes to R0 are tracked like any other register (no hardwired zero register).
//  On retire && !empty: pop head, count[head]-- at next edge.
//  On retire && empty: ignored, err_underflow set; cleared only by reset.
//  Same register pushed and popped in one cycle: count unchanged; occupancy unchanged.
//  Push and pop both active while full: legal only if no stall -- cannot occur, push blocked by stall.
//  flush: next edge empties queue, zeroes all counts; flush dominates concurrent accept and retire.
//  WAW: no stall; multiple in-flight writes to one register raise its count.
//  Pointers wrap modulo DEPTH; count never exceeds DEPTH, so it cannot overflow.
//  Latency: stall is same-cycle from inputs; state updates visible one cycle after the edge.
// CONFIGURATION
//  SCBD_BYPASS_EN defined: writeback-to-issue bypass. A source that matches retire_rd with count==1,
//   with retire && !empty active, does not raise raw.
//  SCBD_BYPASS_EN undefined: any nonzero count raises raw, including the retiring-register case.
// STRUCTURE
//  Shared package wisc_pkg: REG_ID_W=3, NUM_REGS=8, REG_R7=3'b111 constant; reg_id_t typedef.
//  Sub-module scbd_fifo: DEPTH x 3-bit in-order queue with push/pop/flush, full/empty/occupancy.
//  Top level holds the count array, stall logic and bypass logic.
// TESTING
//  1 ADD (rd=3, we=1) accepted; next cycle id_rs=3, rs_en=1 -> stall=1, pending=8'h08.
//  2 Retire in scenario 1 -> count[3]=0 after the edge; stall drops. With SCBD_BYPASS_EN, stall=0 in the
//    retire cycle itself.
//  3 Push DEPTH=4 writes (rd 1,2,3,4) -> full=1. A 5th write, sources clear -> stall=1. A branch with
//    we=0 -> stall=0.
//  4 Two writes to rd=5 -> count 2. One retire -> pending[5] still 1. Second retire -> pending[5]=0.
//  5 Queue holds 3 entries; flush with id_valid and retire in the same cycle -> occupancy=0, pending=0,
//    the issuing write is not recorded.
//  6 Retire while empty -> err_underflow=1, counts unchanged. Assert rst_n=0 mid-stream -> all outputs
//    return to reset values without a clock edge.

Source files
------------

// File: rtl/reg_write_scoreboard_pkg.sv
// Shared register-file constants and types for the issue-side write scoreboard.
package wisc_pkg;

    localparam int REG_ID_W = 3;
    localparam int NUM_REGS = 8;
    localparam logic [REG_ID_W-1:0] REG_R7 = 3'b111;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    localparam int SCBD_DEPTH = 4;
    localparam int SCBD_CNT_W = 3;

    function automatic int scbd_occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_write_scoreboard_if.sv
// Issue/writeback signal bundle for reg_write_scoreboard.
// Handshake: an instruction issues on a cycle where id_valid=1, stall=0 and flush=0;
// retire is a single-cycle pulse with no back-pressure.
interface reg_write_scoreboard_if
    import wisc_pkg::*;
#(
    parameter int DEPTH = SCBD_DEPTH
);
    localparam int OCC_W = scbd_occ_w(DEPTH);

    logic             id_valid;
    reg_id_t          id_rs;
    logic             id_rs_en;
    reg_id_t          id_rt;
    logic             id_rt_en;
    reg_id_t          id_rd;
    logic             id_we_reg;
    logic             retire;
    logic             flush;
    logic             stall;
    reg_id_t          retire_rd;
    logic [NUM_REGS-1:0] pending;
    logic             full;
    logic             empty;
    logic [OCC_W-1:0] occupancy;
    logic             err_underflow;

    modport master (
        output id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_we_reg, retire, flush,
        input  stall, retire_rd, pending, full, empty, occupancy, err_underflow
    );

    modport slave (
        input  id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_we_reg, retire, flush,
        output stall, retire_rd, pending, full, empty, occupancy, err_underflow
    );

endinterface

// File: rtl/reg_write_scoreboard_fifo.sv
// scbd_fifo: in-order queue of destination register ids; flush has priority over push/pop.
module scbd_fifo
    import wisc_pkg::*;
#(
    parameter int DEPTH = SCBD_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  reg_id_t          push_data,
    output reg_id_t          head,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);

    reg_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    assign head      = mem[rd_ptr];
    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign occupancy = occ;

endmodule

// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: per-register pending counts, RAW stall, in-order writeback queue.
// Optional writeback-to-issue bypass enabled by defining SCBD_BYPASS_EN.
module reg_write_scoreboard
    import wisc_pkg::*;
#(
    parameter int DEPTH = SCBD_DEPTH,
    parameter int CNT_W = SCBD_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_write_scoreboard_if.slave bus
);

    localparam int OCC_W = scbd_occ_w(DEPTH);

    logic [CNT_W-1:0] count [NUM_REGS];
    reg_id_t          head;
    logic             full;
    logic             empty;
    logic [OCC_W-1:0] occupancy;
    logic             pop_req;
    logic             push;
    logic             pop;
    logic             rs_busy;
    logic             rt_busy;
    logic             raw;
    logic             stall;
    logic             err_underflow;
    logic [NUM_REGS-1:0] pending;

    assign pop_req = bus.retire && !empty;

    always_comb begin
        rs_busy = bus.id_rs_en && (count[bus.id_rs] != '0);
        rt_busy = bus.id_rt_en && (count[bus.id_rt] != '0);
`ifdef SCBD_BYPASS_EN
        // The last in-flight write to a source is completing now, so its value is on the writeback path.
        if (pop_req && bus.id_rs == head && count[bus.id_rs] == CNT_W'(1)) rs_busy = 1'b0;
        if (pop_req && bus.id_rt == head && count[bus.id_rt] == CNT_W'(1)) rt_busy = 1'b0;
`endif
        raw   = rs_busy || rt_busy;
        // Full is judged on current occupancy; a same-cycle retire does not free a slot for issue.
        stall = bus.id_valid && (raw || (bus.id_we_reg && full));
        push  = bus.id_valid && !stall && !bus.flush && bus.id_we_reg;
        pop   = pop_req && !bus.flush;
    end

    scbd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (bus.flush),
        .push_data (bus.id_rd),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (push && bus.id_rd == reg_id_t'(r) && !(pop && head == reg_id_t'(r)))
                    count[r] <= count[r] + 1'b1;
                else if (pop && head == reg_id_t'(r) && !(push && bus.id_rd == reg_id_t'(r)))
                    count[r] <= count[r] - 1'b1;
            end
        end
    end

    // A retire against an empty queue while flushing is absorbed by the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               err_underflow <= 1'b0;
        else if (bus.retire && empty && !bus.flush) err_underflow <= 1'b1;
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NUM_REGS; r++) pending[r] = (count[r] != '0);
    end

    assign bus.stall         = stall;
    assign bus.retire_rd     = head;
    assign bus.pending       = pending;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.occupancy     = occupancy;
    assign bus.err_underflow = err_underflow;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed table-driven bench for reg_write_scoreboard; honours SCBD_BYPASS_EN for stall expectations.
module tb_reg_write_scoreboard;
    import wisc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    reg_write_scoreboard_if #(.DEPTH(DEPTH)) bus ();

    reg_write_scoreboard #(.DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic [2:0] rs;
        logic       rs_en;
        logic [2:0] rt;
        logic       rt_en;
        logic [2:0] rd;
        logic       we;
        logic       ret;
        logic       fl;
        logic       st;
        logic       st_byp;
        logic [7:0] pend;
        logic [2:0] occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int v, int rs, int rs_en, int rt, int rt_en, int rd, int we,
                                int ret, int fl, int st, int st_byp, int pend, int occ);
        vec_t t;
        t.v = 1'(v);   t.rs = 3'(rs); t.rs_en = 1'(rs_en); t.rt = 3'(rt); t.rt_en = 1'(rt_en);
        t.rd = 3'(rd); t.we = 1'(we); t.ret = 1'(ret);     t.fl = 1'(fl);
        t.st = 1'(st); t.st_byp = 1'(st_byp); t.pend = 8'(pend); t.occ = 3'(occ);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rs_en = 0; bus.id_rt = 0; bus.id_rt_en = 0;
        bus.id_rd = 0; bus.id_we_reg = 0; bus.retire = 0; bus.flush = 0;
    endtask

    task automatic check_state(input string tag, input logic [7:0] pend, input logic [2:0] occ);
        chk({tag, "_pending"}, 32'(bus.pending), 32'(pend));
        chk({tag, "_occ"}, 32'(bus.occupancy), 32'(occ));
        chk({tag, "_full"}, 32'(bus.full), 32'(occ == 3'(DEPTH)));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(occ == 3'd0));
        if (exp_q.size() > 0) chk({tag, "_retire_rd"}, 32'(bus.retire_rd), 32'(exp_q[0]));
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic exp_st;
`ifdef SCBD_BYPASS_EN
        exp_st = t.st_byp;
`else
        exp_st = t.st;
`endif
        @(negedge clk);
        bus.id_valid = t.v;  bus.id_rs = t.rs; bus.id_rs_en = t.rs_en; bus.id_rt = t.rt;
        bus.id_rt_en = t.rt_en; bus.id_rd = t.rd; bus.id_we_reg = t.we;
        bus.retire = t.ret; bus.flush = t.fl;
        #1;
        chk($sformatf("v%0d_stall", idx), 32'(bus.stall), 32'(exp_st));
        @(posedge clk);
        #1;
        if (t.fl) exp_q.delete();
        else begin
            if (t.ret && exp_q.size() > 0) void'(exp_q.pop_front());
            if (t.v && !exp_st && t.we) exp_q.push_back(t.rd);
        end
        check_state($sformatf("v%0d", idx), t.pend, t.occ);
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #2;
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_err", 32'(bus.err_underflow), 0);
        chk("rst_retire_rd", 32'(bus.retire_rd), 0);
        check_state("rst", 8'h00, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //       v rs e rt e rd we ret fl st byp pend occ
        tbl.push_back(mk(1,0,0,0,0,3,1,0,0,0,0,'h08,1));      // write r3
        tbl.push_back(mk(1,3,1,0,0,0,0,0,0,1,1,'h08,1));      // RAW on r3
        tbl.push_back(mk(1,3,1,0,0,0,0,1,0,1,0,'h00,0));      // retire r3, bypass case
        tbl.push_back(mk(1,3,1,0,0,0,0,0,0,0,0,'h00,0));
        tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0,0,'h02,1));      // fill to DEPTH
        tbl.push_back(mk(1,0,0,0,0,2,1,0,0,0,0,'h06,2));
        tbl.push_back(mk(1,0,0,0,0,3,1,0,0,0,0,'h0E,3));
        tbl.push_back(mk(1,0,0,0,0,4,1,0,0,0,0,'h1E,4));
        tbl.push_back(mk(1,0,0,0,0,6,1,0,0,1,1,'h1E,4));      // 5th write stalls on full
        tbl.push_back(mk(1,int'(REG_R7),1,int'(REG_R7),1,0,0,0,0,0,0,'h1E,4)); // branch, no write
        tbl.push_back(mk(1,0,0,0,0,6,1,1,0,1,1,'h1C,3));      // full + retire: still stalls
        tbl.push_back(mk(0,3,1,0,0,0,0,1,0,0,0,'h18,2));      // no id_valid: no stall
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,'h10,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,'h00,0));
        tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,'h20,1));      // WAW on r5
        tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,'h20,2));
        tbl.push_back(mk(1,5,1,0,0,0,0,1,0,1,1,'h20,1));      // count 2: no bypass
        tbl.push_back(mk(1,5,1,0,0,0,0,1,0,1,0,'h00,0));      // count 1: bypass
        tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0,0,'h02,1));
        tbl.push_back(mk(1,0,0,0,0,2,1,0,0,0,0,'h06,2));
        tbl.push_back(mk(1,0,0,0,0,3,1,0,0,0,0,'h0E,3));
        tbl.push_back(mk(1,0,0,0,0,7,1,1,1,0,0,'h00,0));      // flush beats issue + retire
        tbl.push_back(mk(1,0,0,0,0,0,1,0,0,0,0,'h01,1));      // r0 is tracked
        tbl.push_back(mk(1,0,1,0,0,0,0,0,0,1,1,'h01,1));
        tbl.push_back(mk(1,0,0,1,1,0,1,0,0,0,0,'h01,2));      // rs_en=0 masks r0
        tbl.push_back(mk(1,0,0,0,0,0,1,1,0,0,0,'h01,2));      // push+pop same reg
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,'h01,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,'h00,0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Retire while empty: sticky error, nothing else moves.
        chk("pre_underflow_err", 32'(bus.err_underflow), 0);
        apply(mk(0,0,0,0,0,0,0,1,0,0,0,'h00,0), 100);
        chk("underflow_err", 32'(bus.err_underflow), 1);
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,'h00,0), 101);
        chk("underflow_sticky", 32'(bus.err_underflow), 1);

        // Mid-stream asynchronous reset.
        apply(mk(1,0,0,0,0,2,1,0,0,0,0,'h04,1), 102);
        apply(mk(1,0,0,0,0,4,1,0,0,0,0,'h14,2), 103);
        @(negedge clk);
        drive_idle();
        bus.id_valid = 1; bus.id_rs = 2; bus.id_rs_en = 1;
        #1;
        chk("pre_areset_stall", 32'(bus.stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("areset_stall", 32'(bus.stall), 0);
        chk("areset_err", 32'(bus.err_underflow), 0);
        chk("areset_retire_rd", 32'(bus.retire_rd), 0);
        check_state("areset", 8'h00, 3'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
